// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction
// fetch and the data stage. Data has priority; fetch is guaranteed a grant
// after STARVE_MAX consecutive data grants made while it was waiting.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [2:0]  dm_ctrl,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        stallF,
  output logic        stallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_ctrl,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } arbState_t;

  arbState_t       state;
  logic [CntW-1:0] starveCnt;
  logic            fetchStarved;

  // Fetch has waited through the maximum run of data grants
  assign fetchStarved = if_req && (starveCnt == StarveMax);

  // Pipeline freezes while its request is outstanding
  assign stallF = if_req & ~if_valid;
  assign stallM = dm_req & ~dm_valid;

  // Arbitration FSM with registered memory-side and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      starveCnt <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_ctrl  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_req && !fetchStarved) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_ctrl  <= dm_ctrl;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (if_req) begin
              if (starveCnt < StarveMax) begin
                starveCnt <= starveCnt + 1'b1;
              end
            end else begin
              starveCnt <= '0;
            end
          end else if (if_req) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_ctrl  <= 3'b010;
            mem_addr  <= if_addr;
            starveCnt <= '0;
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= RESP;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
            dm_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= RESP;
          end
        end
        RESP: begin
          // Requester is still dropping its request; skip arbitration
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the pipeline's instruction-fetch stage and memory stage. Each stage raises a request and holds it until a one-cycle `valid` pulse; the arbiter serialises requests onto the memory port, waits for the memory acknowledge and returns read data. It also drives the fetch and memory stall signals that freeze the pipeline while a request is outstanding. Data accesses have priority, with a bounded-starvation guard for fetch.

## Interface
- STARVE_MAX, 4: maximum consecutive data grants allowed while fetch is waiting (≥1).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until `if_valid`.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched instruction; valid when `if_valid` is high, held otherwise.
- if_valid  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held until `dm_valid`.
- dm_we  in  1  1 = store, 0 = load.
- dm_ctrl  in  3  store/load size code (strCtrl encoding), passed through.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; updated only on loads.
- dm_valid  out  1  one-cycle completion pulse for data.
- stallF  out  1  `if_req & ~if_valid` (combinational).
- stallM  out  1  `dm_req & ~dm_valid` (combinational).
- mem_req  out  1  memory request; held until `mem_ack`.
- mem_we, mem_ctrl, mem_addr, mem_wdata  out  1/3/32/32  registered copy of the granted request.
- mem_ack  in  1  memory completion; sampled only while `mem_req` = 1.
- mem_rdata  in  32  read data, valid in the `mem_ack` cycle.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - If `dm_req`, and not (`if_req` and starve_cnt == STARVE_MAX): grant data, latch `dm_*` into `mem_*` (`mem_we` = `dm_we`), go to BUSY_D.
  - Else if `if_req`: grant fetch, latch `if_addr`, force `mem_we` = 0 and `mem_ctrl` = 3'b010, go to BUSY_I.
  - Else stay in IDLE.
- BUSY_x: `mem_req` = 1 and all `mem_*` outputs are stable. When `mem_ack` = 1:
  - Capture `mem_rdata` into `if_rdata` (BUSY_I) or into `dm_rdata` (BUSY_D with `mem_we` = 0).
  - Deassert `mem_req`, go to RESP, and set the matching `valid` for the RESP cycle.
- RESP: exactly one `valid` is high. No arbitration (the requester is still dropping its request). Next state is IDLE unconditionally.
- starve_cnt (width clog2(STARVE_MAX+1)), updated at each grant:
  - Data grant with `if_req` = 1: increment, saturating at STARVE_MAX.
  - Fetch grant: clear.
  - Data grant with `if_req` = 0: clear.
- Requesters may change `*_addr`/`*_wdata` after the grant without effect, because `mem_*` are registered copies.
- `mem_ack` while `mem_req` = 0 is ignored.

## Timing
- Grant is decided in IDLE cycle T. `mem_req` rises at T+1.
- Earliest ack is at T+1; `valid` then rises at T+2 (RESP) and the FSM is in IDLE at T+3. Minimum service period is 3 cycles per access.
- Each wait state (cycle with `mem_ack` = 0 while `mem_req` = 1) adds one cycle. There is no timeout.
- Reset values: state IDLE, starve_cnt 0, `mem_req`/`mem_we` 0, `mem_ctrl` 0, `mem_addr`/`mem_wdata` 0, `if_rdata`/`dm_rdata` 0, `if_valid`/`dm_valid` 0.
- Reset mid-transaction: at the edge where `rst` = 1, `mem_req` drops and the state becomes IDLE. A late `mem_ack` after reset produces no `valid` and no rdata update.
- Simultaneous `if_req` and `dm_req` in IDLE: data wins unless starve_cnt == STARVE_MAX.
- `stallF`/`stallM` are high in the same cycle the request rises, and low in the `valid` cycle.

## Test plan
- Reset, then `if_req` = 1 with `if_addr` = 0x0000_0010, ack at the first `mem_req` cycle, `mem_rdata` = 0x0030_0093 → `mem_addr` = 0x10 and `mem_we` = 0 at T+1; `if_valid` = 1 and `if_rdata` = 0x0030_0093 at T+2; `stallF` = 0 at T+2.
- Store `dm_we` = 1, `dm_ctrl` = 3'b010, `dm_addr` = 0x100, `dm_wdata` = 0xDEAD_BEEF; ack after 4 wait states → `mem_*` stable for all 5 `mem_req` cycles; single `dm_valid` pulse; `dm_rdata` unchanged (0).
- `if_req` and `dm_req` both rise in the same cycle → data is granted first (`mem_addr` = `dm_addr`), fetch is granted in the IDLE after data's RESP.
- STARVE_MAX = 2, `dm_req` held continuously (re-raised after each `valid`), `if_req` held → grant order D, D, F, D, D, F.
- Reset asserted during BUSY_D, `mem_ack` pulsed 2 cycles later → `mem_req` = 0 after the reset edge; `dm_valid` never pulses; `dm_rdata` = 0.
- `mem_ack` = 1 while in IDLE with no requests → no `valid` pulse, state remains IDLE.
